// File: rtl/layer_scheduler_pkg.sv
// Shared types and constants for the layer-multiplexed training sequencer.
package layer_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFwdIssue,
    StFwdWait,
    StBwdIssue,
    StBwdWait,
    StDone
  } sched_state_t;

  localparam int unsigned DEFAULT_LAYER_MAX = 3;
  localparam int unsigned LAST_LAYER        = DEFAULT_LAYER_MAX - 1;

  function automatic int unsigned last_layer(input int unsigned layer_max);
    return layer_max - 1;
  endfunction

endpackage

// File: rtl/layer_scheduler.sv
// Sequences forward layers 0..LAYER_MAX-1 then backward layers LAYER_MAX-1..0 per sample.
// Backward pass is built only when LAYER_SCHEDULER_TRAIN_EN is defined (inference-only otherwise).
module layer_scheduler
  import layer_scheduler_pkg::*;
#(
  parameter int unsigned LAYER_ADDR_WIDTH = 2,
  parameter int unsigned LAYER_MAX        = DEFAULT_LAYER_MAX,
  parameter int unsigned COUNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_valid,
  output logic                        start_ready,
  output logic [LAYER_ADDR_WIDTH-1:0] fwd_layer,
  output logic                        fwd_layer_valid,
  input  logic                        fwd_layer_ready,
  input  logic                        fwd_done,
  output logic [LAYER_ADDR_WIDTH-1:0] bwd_layer,
  output logic                        bwd_layer_valid,
  input  logic                        bwd_layer_ready,
  input  logic                        bwd_done,
  output logic                        sample_done,
  output logic [COUNT_WIDTH-1:0]      sample_count,
  output logic                        busy,
  output logic                        protocol_error
);

  localparam logic [LAYER_ADDR_WIDTH-1:0] LastIdx = LAYER_ADDR_WIDTH'(last_layer(LAYER_MAX));

  sched_state_t                state_q, state_d;
  logic [LAYER_ADDR_WIDTH-1:0] layer_q, layer_d;
  logic [COUNT_WIDTH-1:0]      count_q, count_d;
  logic                        perr_q, perr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      layer_q <= '0;
      count_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      count_q <= count_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    layer_d         = layer_q;
    count_d         = count_q;
    perr_d          = perr_q;
    fwd_layer_valid = 1'b0;
    bwd_layer_valid = 1'b0;
    sample_done     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_valid) begin
          layer_d = '0;
          state_d = StFwdIssue;
        end
      end
      StFwdIssue: begin
        fwd_layer_valid = 1'b1;
        if (fwd_layer_ready) state_d = StFwdWait;
      end
      StFwdWait: begin
        if (fwd_done) begin
          if (layer_q == LastIdx) begin
`ifdef LAYER_SCHEDULER_TRAIN_EN
            state_d = StBwdIssue;
`else
            state_d = StDone;
`endif
          end else begin
            layer_d = layer_q + 1'b1;
            state_d = StFwdIssue;
          end
        end
      end
`ifdef LAYER_SCHEDULER_TRAIN_EN
      StBwdIssue: begin
        bwd_layer_valid = 1'b1;
        if (bwd_layer_ready) state_d = StBwdWait;
      end
      StBwdWait: begin
        if (bwd_done) begin
          if (layer_q == '0) begin
            state_d = StDone;
          end else begin
            layer_d = layer_q - 1'b1;
            state_d = StBwdIssue;
          end
        end
      end
`endif
      StDone: begin
        sample_done = 1'b1;
        count_d     = count_q + 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A done pulse is only consumed by its own WAIT state; anything else is a protocol fault.
    if (fwd_done && (state_q != StFwdWait)) perr_d = 1'b1;
`ifdef LAYER_SCHEDULER_TRAIN_EN
    if (bwd_done && (state_q != StBwdWait)) perr_d = 1'b1;
`else
    if (bwd_done) perr_d = 1'b1;
`endif
  end

  assign start_ready    = (state_q == StIdle) && !rst;
  assign busy           = (state_q != StIdle);
  assign fwd_layer      = layer_q;
  assign sample_count   = count_q;
  assign protocol_error = perr_q;

`ifdef LAYER_SCHEDULER_TRAIN_EN
  assign bwd_layer = layer_q;
`else
  logic unused_bwd_ready;
  assign unused_bwd_ready = bwd_layer_ready;
  assign bwd_layer        = '0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler; expectations follow LAYER_SCHEDULER_TRAIN_EN.
module tb_layer_scheduler;

  localparam int unsigned AW = 2;
  localparam int unsigned L  = 3;
  localparam int unsigned CW = 2;

`ifdef LAYER_SCHEDULER_TRAIN_EN
  localparam int unsigned NPASS     = 2;
  localparam logic        ABORT_DIR = 1'b1;
`else
  localparam int unsigned NPASS     = 1;
  localparam logic        ABORT_DIR = 1'b0;
`endif

  typedef struct packed {
    logic          dir;  // 0 forward, 1 backward
    logic [AW-1:0] layer;
  } item_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid, start_ready;
  logic [AW-1:0] fwd_layer, bwd_layer;
  logic          fwd_layer_valid, fwd_layer_ready, fwd_done;
  logic          bwd_layer_valid, bwd_layer_ready, bwd_done;
  logic          sample_done, busy, protocol_error;
  logic [CW-1:0] sample_count;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_count;
  item_t         q[$];

  always #5 clk = ~clk;

  layer_scheduler #(
    .LAYER_ADDR_WIDTH(AW),
    .LAYER_MAX       (L),
    .COUNT_WIDTH     (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .fwd_layer      (fwd_layer),
    .fwd_layer_valid(fwd_layer_valid),
    .fwd_layer_ready(fwd_layer_ready),
    .fwd_done       (fwd_done),
    .bwd_layer      (bwd_layer),
    .bwd_layer_valid(bwd_layer_valid),
    .bwd_layer_ready(bwd_layer_ready),
    .bwd_done       (bwd_done),
    .sample_done    (sample_done),
    .sample_count   (sample_count),
    .busy           (busy),
    .protocol_error (protocol_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fwd_valid"}, 32'(fwd_layer_valid), 32'd0);
    check({tag, "_bwd_valid"}, 32'(bwd_layer_valid), 32'd0);
    check({tag, "_sample_done"}, 32'(sample_done), 32'd0);
    check({tag, "_count"}, 32'(sample_count), 32'd0);
    check({tag, "_perr"}, 32'(protocol_error), 32'd0);
    check({tag, "_fwd_layer"}, 32'(fwd_layer), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
    exp_count = '0;
    step();
    check("rst_start_ready", 32'(start_ready), 32'd1);
  endtask

  // Runs one sample. hold: ready-low cycles on forward layer 1. both_layer: forward layer whose
  // done is accompanied by a stray bwd_done. abort_layer: reset after this layer's handshake.
  task automatic run_sample(input int hold, input int done_lat, input int both_layer,
                            input int abort_layer);
    int    cyc = 0;
    int    pend = 0;
    int    held = 0;
    int    exp_step;
    logic  last_dir = 1'b0;
    logic  both = 1'b0;
    logic  aborting = 1'b0;
    logic  finished = 1'b0;
    item_t it;

    for (int l = 0; l < int'(L); l++) q.push_back(item_t'{dir: 1'b0, layer: AW'(l)});
    for (int l = int'(L) - 1; l >= 0 && NPASS == 2; l--)
      q.push_back(item_t'{dir: 1'b1, layer: AW'(l)});
    exp_step = 1 + int'(NPASS * L) * (1 + done_lat) + ((L > 1) ? hold : 0);

    check("start_ready_before", 32'(start_ready), 32'd1);
    start_valid     = 1'b1;
    fwd_layer_ready = 1'b1;
    bwd_layer_ready = 1'b1;
    while (!finished) begin
      step();
      cyc++;
      start_valid = 1'b0;
      fwd_done    = 1'b0;
      bwd_done    = 1'b0;
      fwd_layer_ready = 1'b1;
      if (aborting) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        check("abort_start_ready_in_rst", 32'(start_ready), 32'd0);
        #2;
        rst = 1'b0;
        q.delete();
        exp_count = '0;
        step();
        check("abort_start_ready", 32'(start_ready), 32'd1);
        check("abort_count", 32'(sample_count), 32'd0);
        return;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fwd_done = !last_dir || both;
          bwd_done = last_dir || both;
        end
      end
      if (fwd_layer_valid || bwd_layer_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_valid observed=%0b%0b expected=00", fwd_layer_valid,
                 bwd_layer_valid);
        end else begin
          it = q[0];
          check("valid_dir", {30'd0, fwd_layer_valid, bwd_layer_valid},
                it.dir ? 32'd1 : 32'd2);
          check(it.dir ? "bwd_layer" : "fwd_layer", 32'(it.dir ? bwd_layer : fwd_layer),
                32'(it.layer));
          if (!it.dir && it.layer == AW'(1) && held < hold) begin
            fwd_layer_ready = 1'b0;
            held++;
          end else begin
            void'(q.pop_front());
            pend     = done_lat;
            last_dir = it.dir;
            both     = !it.dir && (int'(it.layer) == both_layer);
            aborting = (it.dir == ABORT_DIR) && (int'(it.layer) == abort_layer);
          end
        end
      end
      if (sample_done) begin
        check("done_step", 32'(cyc), 32'(exp_step));
        check("queue_empty", 32'(q.size()), 32'd0);
        exp_count = exp_count + 1'b1;
        step();
        check("done_pulse_width", 32'(sample_done), 32'd0);
        check("start_ready_after", 32'(start_ready), 32'd1);
        check("sample_count", 32'(sample_count), 32'(exp_count));
        finished = 1'b1;
      end else if (cyc > 300) begin
        checks++;
        errors++;
        $error("FAIL timeout observed=%0d expected=%0d", cyc, exp_step);
        q.delete();
        finished = 1'b1;
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    start_valid     = 1'b0;
    fwd_layer_ready = 1'b1;
    bwd_layer_ready = 1'b1;
    fwd_done        = 1'b0;
    bwd_done        = 1'b0;
    exp_count       = '0;
    step();
    step();
    do_reset();

    // Basic sequence, late done, then ready stall on layer 1, then minimum-latency timing.
    run_sample(0, 2, -1, -1);
    check("perr_clean", 32'(protocol_error), 32'd0);
    run_sample(5, 1, -1, -1);
    run_sample(0, 1, -1, -1);
    check("perr_clean2", 32'(protocol_error), 32'd0);

    // Simultaneous fwd_done/bwd_done in FWD_WAIT: sequencing continues, error flagged.
    do_reset();
    run_sample(0, 1, 0, -1);
    check("perr_both", 32'(protocol_error), 32'd1);

    // Stray fwd_done while idle.
    do_reset();
    fwd_done = 1'b1;
    step();
    fwd_done = 1'b0;
    check("stray_start_ready", 32'(start_ready), 32'd1);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_perr", 32'(protocol_error), 32'd1);
    step();
    step();
    check("stray_perr_sticky", 32'(protocol_error), 32'd1);

    // Reset mid-sample; abort task resets exp_count itself.
    run_sample(0, 3, -1, 1);

    // Back-to-back samples exercise the counter wrap.
    for (int s = 0; s < 5; s++) run_sample(0, 1, -1, -1);
    check("wrap_final", 32'(sample_count), 32'd1);
    check("perr_end", 32'(protocol_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
